muldiv_iter: RTL and testbench

- Parametrised iterative multiply/divide unit for the EX stage.
- Replaces the combinational multiplier and the fixed 32-bit radix-2 divider with one shared shift/add datapath covering MULT, MULTU, DIV and DIVU.
- Uses a start/done handshake, a stall output for the pipeline, a flush/cancel input and defined divide-by-zero results.
- Results are returned as {hi, lo} for writing into the HILO register.

---
 rtl/muldiv_iter.sv | 162 ++++++++++++++++
 tb/tb_muldiv_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and divide (MULT, MULTU, DIV, DIVU) on one shared shift/add datapath.
// Latency: start sampled at edge E0, done pulses in the cycle after edge E(WIDTH+1), for every op.
// Backpressure: stall holds the pipeline from the accepted start cycle through FIN; cancel aborts at the next edge.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   start, op, a, b   request with opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) and operands, sampled in IDLE
//   cancel            flush: drop any operation in progress, no done pulse
//   stall             combinational pipeline hold request
//   done              one-cycle result-valid pulse
//   hi, lo            product {hi,lo} or remainder/quotient; held until the next completed op
//   div_by_zero       set with done when a divide had b == 0
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;    // negate product (mul) or quotient (div)
  logic               neg_r;    // negate remainder (signed divide, negative dividend)
  logic               b_zero;
  logic [WIDTH-1:0]   mag_b;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc;

  // Operand magnitudes and signs at acceptance.
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // Shared WIDTH+1 bit adder: adds the multiplicand for a multiply step,
  // subtracts the divisor from the shifted remainder for a divide step.
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic [WIDTH:0]     sum;
  logic               q_bit;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    acc_hi = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      add_x = {acc_hi, acc[WIDTH-1]};
      add_y = ~{1'b0, mag_b};
    end else begin
      add_x = {1'b0, acc_hi};
      add_y = acc[0] ? {1'b0, mag_b} : '0;
    end
    sum = add_x + add_y + (WIDTH+1)'(is_div);
    // Shifted remainder is always below 2*divisor, so bit WIDTH of the
    // difference is a clean borrow flag.
    q_bit    = ~sum[WIDTH];
    mul_next = {sum, acc[WIDTH-1:1]};
    div_next = {(q_bit ? sum[WIDTH-1:0] : {acc_hi[WIDTH-2:0], acc[WIDTH-1]}),
                acc[WIDTH-2:0], q_bit};
  end

  // Sign correction. With a zero divisor every trial subtract succeeds, so the
  // remainder ends up holding |a|; restoring its sign gives back a unchanged.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_q ? (~acc + (2*WIDTH)'(1)) : acc;
    quo_fix  = b_zero ? '1 : (neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0]);
    rem_fix  = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      mag_b       <= '0;
      acc         <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= op[1] & a_neg;
            b_zero <= (b == '0);
            mag_b  <= b_mag;
            acc    <= {{WIDTH{1'b0}}, a_mag};
            cnt    <= CNT_W'(WIDTH);
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          // A flush arriving in FIN discards the result entirely.
          if (!cancel) begin
            done        <= 1'b1;
            div_by_zero <= is_div & b_zero;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall = ((state == S_IDLE) & start & ~cancel) | (state == S_CALC) | (state == S_FIN);

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32, start8, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;

  logic        stall32, done32, dbz32;
  logic [31:0] hi32, lo32;
  logic        stall8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  muldiv_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op), .a(a), .b(b), .cancel(cancel),
    .stall(stall32), .done(done32), .hi(hi32), .lo(lo32), .div_by_zero(dbz32)
  );

  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op), .a(a8), .b(b8), .cancel(cancel),
    .stall(stall8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
  );

  // Selected-instance view so one task drives either width.
  logic        sel8;
  logic        m_stall, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  assign m_stall = sel8 ? stall8 : stall32;
  assign m_done  = sel8 ? done8  : done32;
  assign m_dbz   = sel8 ? dbz8   : dbz32;
  assign m_hi    = sel8 ? {24'b0, hi8} : hi32;
  assign m_lo    = sel8 ? {24'b0, lo8} : lo32;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model for 32-bit ops, built on the simulator's own arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t   r;
    longint sx, sy, p, q, rm;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (o)
      2'd0: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin u = {32'b0, x} * {32'b0, y}; r.hi = u[63:32]; r.lo = u[31:0]; end
      2'd2: begin
        if (y == 32'd0) begin r.hi = x; r.lo = '1; r.dbz = 1'b1; end
        else begin q = sx / sy; rm = sx % sy; r.lo = q[31:0]; r.hi = rm[31:0]; end
      end
      default: begin
        if (y == 32'd0) begin r.hi = x; r.lo = '1; r.dbz = 1'b1; end
        else begin r.lo = x / y; r.hi = x % y; end
      end
    endcase
    return r;
  endfunction

  // Issue one op in the next cycle, push its expectation, then wait (bounded)
  // for done and check latency, stall profile and the result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] ia,
                        input logic [31:0] ib, input exp_t e);
    int   w;
    bit   seen;
    exp_t got;
    w = sel8 ? 8 : 32;
    @(negedge clk);
    sb.push_back(e);
    op = o; a = ia; b = ib; a8 = ia[7:0]; b8 = ib[7:0];
    if (sel8) start8 = 1'b1; else start32 = 1'b1;
    #1 check({tag, " stall_in_start_cycle"}, 64'(m_stall), 64'(1));
    @(negedge clk);
    start32 = 1'b0; start8 = 1'b0;
    // Operands may change once accepted.
    op = 2'($urandom); a = $urandom; b = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    seen = 1'b0;
    for (int k = 1; k <= w + 4 && !seen; k++) begin
      @(negedge clk);
      if (k <= w) check({tag, " stall_busy"}, 64'(m_stall), 64'(1));
      if (m_done) begin
        seen = 1'b1;
        got  = sb.pop_front();
        check({tag, " latency"}, 64'(k), 64'(w + 1));
        check({tag, " stall_done_cycle"}, 64'(m_stall), 64'(0));
        check({tag, " hi"}, 64'(m_hi), 64'(got.hi));
        check({tag, " lo"}, 64'(m_lo), 64'(got.lo));
        check({tag, " div_by_zero"}, 64'(m_dbz), 64'(got.dbz));
        last_hi = got.hi;
        last_lo = got.lo;
      end
    end
    check({tag, " done_seen"}, 64'(seen), 64'(1));
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic z);
    exp_t r;
    r.hi = h; r.lo = l; r.dbz = z;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    rst = 1'b0; start32 = 1'b0; start8 = 1'b0; cancel = 1'b0; sel8 = 1'b0;
    op = '0; a = '0; b = '0; a8 = '0; b8 = '0;
    #1;
    check("reset stall32", 64'(stall32), 64'(0));
    check("reset done32",  64'(done32),  64'(0));
    check("reset hi32",    64'(hi32),    64'(0));
    check("reset lo32",    64'(lo32),    64'(0));
    check("reset dbz32",   64'(dbz32),   64'(0));
    check("reset hi8",     64'(hi8),     64'(0));
    check("reset lo8",     64'(lo8),     64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    run_op("mult_neg2x3",  2'd0, 32'hFFFFFFFE, 32'h00000003, mk(32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0));
    run_op("multu_max",    2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'hFFFFFFFE, 32'h00000001, 1'b0));
    run_op("div_m7_2",     2'd2, 32'hFFFFFFF9, 32'h00000002, mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0));
    run_op("div_minneg",   2'd2, 32'h80000000, 32'hFFFFFFFF, mk(32'h00000000, 32'h80000000, 1'b0));
    run_op("divu_100_7",   2'd3, 32'd100,      32'd7,        mk(32'd2,        32'd14,        1'b0));
    run_op("divu_by0",     2'd3, 32'h12345678, 32'h0,        mk(32'h12345678, 32'hFFFFFFFF, 1'b1));
    run_op("div_neg_by0",  2'd2, 32'hFFFFFFFB, 32'h0,        mk(32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1));

    for (int i = 0; i < 8; i++) begin
      ro = 2'(i);
      ra = $urandom;
      rb = (i == 6) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op("random", ro, ra, rb, model(ro, ra, rb));
    end

    // start and cancel together are ignored.
    @(negedge clk);
    start32 = 1'b1; cancel = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    #1 check("start_cancel stall", 64'(stall32), 64'(0));
    @(negedge clk);
    start32 = 1'b0; cancel = 1'b0;
    check("start_cancel idle", 64'(stall32), 64'(0));

    // Cancel mid-CALC.
    @(negedge clk);
    start32 = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_calc stall", 64'(stall32), 64'(0));
    check("cancel_calc hi",    64'(hi32),    64'(last_hi));
    check("cancel_calc lo",    64'(lo32),    64'(last_lo));
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) dn++;
    end
    check("cancel_calc no_done", 64'(dn), 64'(0));

    // Cancel coinciding with FIN wins.
    start32 = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start32 = 1'b0;
    repeat (32) @(negedge clk);
    check("cancel_fin stall_before", 64'(stall32), 64'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_fin done",  64'(done32),  64'(0));
    check("cancel_fin stall", 64'(stall32), 64'(0));
    check("cancel_fin lo",    64'(lo32),    64'(last_lo));

    run_op("multu_6x7", 2'd1, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0));

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start32 = 1'b1; op = 2'd0; a = 32'h7; b = 32'h9;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst stall", 64'(stall32), 64'(0));
    check("async_rst done",  64'(done32),  64'(0));
    check("async_rst hi",    64'(hi32),    64'(0));
    check("async_rst lo",    64'(lo32),    64'(0));
    @(negedge clk);
    rst = 1'b1;

    sel8 = 1'b1;
    run_op("w8_div_m127_2", 2'd2, 32'h81, 32'h02, mk(32'hFF, 32'hC1, 1'b0));
    run_op("w8_mult_min",   2'd0, 32'h80, 32'h80, mk(32'h40, 32'h00, 1'b0));
    run_op("w8_divu_by0",   2'd3, 32'hA5, 32'h00, mk(32'hA5, 32'hFF, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
